filter_ctrl: RTL and testbench

FILTER_CTRL -- requirements
Module: filter_ctrl

---
 rtl/filter_ctrl_pkg.sv | 24 ++
 rtl/filter_ctrl_btn_debounce.sv | 60 ++++++
 rtl/filter_ctrl.sv | 80 ++++++++
 tb/tb_filter_ctrl.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/filter_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : filter_ctrl_pkg
// Purpose  : Shared constants for the colour-filter controller: channel bit
//            positions inside the 3-bit filter mask, the mask width and the
//            default debounce length.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package filter_ctrl_pkg;

  // Bit positions of each colour channel inside {R,G,B} masks.
  localparam int CH_R = 2;
  localparam int CH_G = 1;
  localparam int CH_B = 0;

  // Number of filterable channels.
  localparam int MASK_W = 3;

  // Stable cycles before a button level change is accepted.
  localparam int DEBOUNCE_DEFAULT = 240000;

endpackage : filter_ctrl_pkg
`default_nettype wire

// File: rtl/filter_ctrl_btn_debounce.sv
`default_nettype none
// ============================================================================
// Module   : btn_debounce
// Purpose  : One pushbutton channel: 2-flop synchronizer, stability counter,
//            debounced level and a one-cycle press event on each accepted
//            0->1 change of the debounced level.
// Ports    : clk      - system clock, rising edge
//            rst_n    - asynchronous active-low reset
//            btn_raw  - raw, bouncy, asynchronous button input
//            press    - registered one-cycle press event
// Revision : 1.0 - initial release
// ============================================================================
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = filter_ctrl_pkg::DEBOUNCE_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic press
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             sync_meta;
  logic             sync;
  logic             level;
  logic [CNT_W-1:0] cnt;

  // The counter only advances while the synchronized input disagrees with the
  // debounced level and is cleared as soon as it reaches its terminal value,
  // so it can never wrap.  The press event is registered on the same edge
  // the level rises, giving exactly 2 + DEBOUNCE_CYCLES cycles of latency
  // from a clean raw edge to the event.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_meta <= 1'b0;
      sync      <= 1'b0;
      level     <= 1'b0;
      cnt       <= '0;
      press     <= 1'b0;
    end else begin
      sync_meta <= btn_raw;
      sync      <= sync_meta;
      press     <= 1'b0;
      if (sync == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level <= sync;
        cnt   <= '0;
        press <= sync;
      end else begin
        cnt <= cnt + CNT_ONE;
      end
    end
  end

endmodule : btn_debounce
`default_nettype wire

// File: rtl/filter_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : filter_ctrl
// Purpose  : Colour-filter control. Three debounced pushbuttons toggle bits
//            of a requested mask; the active mask seen by the pixel path only
//            takes the requested value at frame_end, so filters never change
//            mid-frame.
// Ports    : clk         - system clock, rising edge
//            rst_n       - asynchronous active-low reset
//            btn_R/G/B   - raw pushbuttons (active-high, bouncy, async)
//            frame_end   - one-cycle pulse at end of active video
//            filter_R/G/B- registered per-channel zero enables
//            filter_mask - registered {filter_R, filter_G, filter_B}
//            pending     - registered, 1 while requested != active mask
// Revision : 1.0 - initial release
// ============================================================================
module filter_ctrl
  import filter_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              btn_R,
  input  logic              btn_G,
  input  logic              btn_B,
  input  logic              frame_end,
  output logic              filter_R,
  output logic              filter_G,
  output logic              filter_B,
  output logic [MASK_W-1:0] filter_mask,
  output logic              pending
);

  logic [MASK_W-1:0] btn_raw;
  logic [MASK_W-1:0] press;
  logic [MASK_W-1:0] requested;
  logic [MASK_W-1:0] requested_next;
  logic [MASK_W-1:0] active_next;

  assign btn_raw[CH_R] = btn_R;
  assign btn_raw[CH_G] = btn_G;
  assign btn_raw[CH_B] = btn_B;

  for (genvar i = 0; i < MASK_W; i++) begin : g_chan
    btn_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_btn_debounce (
      .clk     (clk),
      .rst_n   (rst_n),
      .btn_raw (btn_raw[i]),
      .press   (press[i])
    );
  end

  // Looking at next-state values lets a press coincident with frame_end be
  // applied on that same edge, and keeps pending low right after frame_end.
  always_comb begin
    requested_next = requested ^ press;
    active_next    = frame_end ? requested_next : filter_mask;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      requested   <= '0;
      filter_mask <= '0;
      pending     <= 1'b0;
    end else begin
      requested   <= requested_next;
      filter_mask <= active_next;
      pending     <= (requested_next != active_next);
    end
  end

  assign filter_R = filter_mask[CH_R];
  assign filter_G = filter_mask[CH_G];
  assign filter_B = filter_mask[CH_B];

endmodule : filter_ctrl
`default_nettype wire

// File: tb/tb_filter_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_filter_ctrl
// Purpose  : Self-checking bench for filter_ctrl with DEBOUNCE_CYCLES = 4.
//            A behavioural model works from the raw button history: a level
//            change is accepted once the synchronized (2-cycle delayed) input
//            has disagreed with the debounced level for D consecutive edges.
// Revision : 1.0 - initial release
// ============================================================================
module tb_filter_ctrl;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_R = 1'b0, btn_G = 1'b0, btn_B = 1'b0;
  logic       frame_end = 1'b0;
  logic       filter_R, filter_G, filter_B;
  logic [2:0] filter_mask;
  logic       pending;

  int total = 0;
  int bad   = 0;

  filter_ctrl #(.DEBOUNCE_CYCLES(D)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .btn_R       (btn_R),
    .btn_G       (btn_G),
    .btn_B       (btn_B),
    .frame_end   (frame_end),
    .filter_R    (filter_R),
    .filter_G    (filter_G),
    .filter_B    (filter_B),
    .filter_mask (filter_mask),
    .pending     (pending)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [2:0] hist[$];
  logic [2:0] m_lvl, m_ev, m_req, m_act;
  logic       m_pend;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist.delete();
      for (int k = 0; k < D + 2; k++) hist.push_back(3'b000);
      m_lvl = '0; m_ev = '0; m_req = '0; m_act = '0; m_pend = 1'b0;
    end else begin
      logic [2:0] rn, an, nev;
      int n;
      bit all_diff;
      rn = m_req ^ m_ev;
      an = frame_end ? rn : m_act;
      m_pend = (rn != an);
      m_req = rn;
      m_act = an;
      hist.push_back({btn_R, btn_G, btn_B});
      n = hist.size();
      nev = '0;
      for (int c = 0; c < 3; c++) begin
        all_diff = 1'b1;
        for (int k = 0; k < D; k++)
          if (hist[n-3-k][c] == m_lvl[c]) all_diff = 1'b0;
        if (all_diff) begin
          m_lvl[c] = ~m_lvl[c];
          if (m_lvl[c]) nev[c] = 1'b1;
        end
      end
      m_ev = nev;
      while (hist.size() > 64) void'(hist.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    tick();
    rst_n = 1'b1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    btn_R = 1; btn_G = 1; btn_B = 1; frame_end = 0;
    rst_n = 1'b0;
    #1;
    total++; if (filter_mask !== 3'b000) begin bad++; $display("FAIL reset_mask got=%b exp=000", filter_mask); end
    total++; if (pending !== 1'b0) begin bad++; $display("FAIL reset_pending got=%b exp=0", pending); end
    total++; if ({filter_R, filter_G, filter_B} !== 3'b000) begin bad++; $display("FAIL reset_rgb got=%b exp=000", {filter_R, filter_G, filter_B}); end
    tick(); tick();
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      total++; if (filter_mask !== 3'b000) begin bad++; $display("FAIL reset_hold_mask cyc=%0d got=%b exp=000", i, filter_mask); end
      total++; if (pending !== m_pend) begin bad++; $display("FAIL reset_hold_pending cyc=%0d got=%b exp=%b", i, pending, m_pend); end
    end
    frame_end = 1; tick(); frame_end = 0;
    total++; if (filter_mask !== 3'b111) begin bad++; $display("FAIL reset_frame_mask got=%b exp=111", filter_mask); end
    total++; if (pending !== 1'b0) begin bad++; $display("FAIL reset_frame_pending got=%b exp=0", pending); end
    btn_R = 0; btn_G = 0; btn_B = 0;
    repeat (10) tick();
  endtask

  task automatic test_clean_press();
    do_reset();
    btn_R = 1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (i <= 7) begin
        total++;
        if (pending !== (i == 7)) begin bad++; $display("FAIL clean_pending edge=%0d got=%b exp=%b", i, pending, (i == 7)); end
      end
    end
    btn_R = 0;
    repeat (8) tick();
    total++; if (filter_mask !== 3'b000) begin bad++; $display("FAIL clean_midframe got=%b exp=000", filter_mask); end
    frame_end = 1; tick(); frame_end = 0;
    total++; if (filter_R !== 1'b1 || filter_mask !== 3'b100) begin bad++; $display("FAIL clean_frame got R=%b mask=%b exp R=1 mask=100", filter_R, filter_mask); end
    total++; if (pending !== 1'b0) begin bad++; $display("FAIL clean_frame_pending got=%b exp=0", pending); end
  endtask

  task automatic test_bounce();
    for (int i = 0; i < 20; i++) begin
      if (i % 2 == 0) btn_G = ~btn_G;
      tick();
      total++; if (pending !== 1'b0 || pending !== m_pend) begin bad++; $display("FAIL bounce_pending cyc=%0d got=%b exp=0", i, pending); end
    end
    btn_G = 0;
    repeat (8) tick();
    frame_end = 1; tick(); frame_end = 0;
    total++; if (filter_mask !== 3'b100) begin bad++; $display("FAIL bounce_mask got=%b exp=100", filter_mask); end
  endtask

  task automatic test_coincidence();
    btn_B = 1;
    repeat (6) tick();
    total++; if (filter_B !== 1'b0 || pending !== 1'b0) begin bad++; $display("FAIL coin_before got B=%b pend=%b exp B=0 pend=0", filter_B, pending); end
    frame_end = 1; tick(); frame_end = 0;
    total++; if (filter_B !== 1'b1 || filter_mask !== 3'b101) begin bad++; $display("FAIL coin_frame got mask=%b exp=101", filter_mask); end
    total++; if (pending !== 1'b0) begin bad++; $display("FAIL coin_pending got=%b exp=0", pending); end
    btn_B = 0;
    repeat (8) tick();
  endtask

  task automatic test_cancel();
    btn_R = 1; repeat (8) tick(); btn_R = 0; repeat (8) tick();
    total++; if (pending !== 1'b1 || pending !== m_pend) begin bad++; $display("FAIL cancel_first got=%b exp=1", pending); end
    btn_R = 1; repeat (8) tick(); btn_R = 0; repeat (8) tick();
    total++; if (pending !== 1'b0 || pending !== m_pend) begin bad++; $display("FAIL cancel_second got=%b exp=0", pending); end
    frame_end = 1; tick(); frame_end = 0;
    total++; if (filter_R !== 1'b1 || filter_mask !== 3'b101) begin bad++; $display("FAIL cancel_frame got mask=%b exp=101", filter_mask); end
  endtask

  task automatic test_mid_reset();
    do_reset();
    btn_G = 1; btn_B = 1; repeat (8) tick(); btn_G = 0; btn_B = 0; repeat (8) tick();
    frame_end = 1; tick(); frame_end = 0;
    total++; if (filter_mask !== 3'b011) begin bad++; $display("FAIL midrst_setup got=%b exp=011", filter_mask); end
    btn_R = 1;
    repeat (4) tick();
    rst_n = 1'b0;
    #1;
    total++; if (filter_mask !== 3'b000 || pending !== 1'b0 || {filter_R, filter_G, filter_B} !== 3'b000) begin bad++; $display("FAIL midrst_zero got mask=%b pend=%b exp mask=000 pend=0", filter_mask, pending); end
    tick();
    rst_n = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      tick();
      total++;
      if (pending !== (i == 7)) begin bad++; $display("FAIL midrst_pending edge=%0d got=%b exp=%b", i, pending, (i == 7)); end
    end
    btn_R = 0;
    repeat (8) tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 5) == 0) btn_R = ~btn_R;
      if ($urandom_range(0, 5) == 0) btn_G = ~btn_G;
      if ($urandom_range(0, 5) == 0) btn_B = ~btn_B;
      frame_end = ($urandom_range(0, 7) == 0);
      tick();
      total++; if (filter_mask !== m_act) begin bad++; $display("FAIL rand_mask cyc=%0d got=%b exp=%b", i, filter_mask, m_act); end
      total++; if ({filter_R, filter_G, filter_B} !== m_act) begin bad++; $display("FAIL rand_rgb cyc=%0d got=%b exp=%b", i, {filter_R, filter_G, filter_B}, m_act); end
      total++; if (pending !== m_pend) begin bad++; $display("FAIL rand_pending cyc=%0d got=%b exp=%b", i, pending, m_pend); end
    end
    frame_end = 0;
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_coincidence();
    test_cancel();
    test_mid_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_filter_ctrl
`default_nettype wire
